// File: rtl/status_capture_reg_pkg.sv
// -----------------------------------------------------------------------------
// status_reg_pkg
// Shared definitions for the parametrised status capture register:
//   - rd_state_e     : read handshake FSM states (IDLE, ACK, HOLD)
//   - MAX_WIDTH      : widest supported status word
//   - SYNC_*         : the legal input synchroniser depths
//   - params_legal() : elaboration-time check of WIDTH / SYNC_STAGES
// -----------------------------------------------------------------------------
package status_reg_pkg;

    localparam int MAX_WIDTH = 32;

    // Legal input synchroniser depths (0 = inputs already in the clock domain).
    localparam int SYNC_NONE  = 0;
    localparam int SYNC_TWO   = 2;
    localparam int SYNC_THREE = 3;

    // Snapshot read handshake states.
    typedef enum logic [1:0] {
        RD_IDLE = 2'b00,
        RD_ACK  = 2'b01,
        RD_HOLD = 2'b10
    } rd_state_e;

    // True when the width and synchroniser depth are inside the supported set.
    function automatic logic params_legal(input int width, input int sync_stages);
        logic width_ok;
        logic sync_ok;
        width_ok = (width >= 1) && (width <= MAX_WIDTH);
        case (sync_stages)
            SYNC_NONE, SYNC_TWO, SYNC_THREE: sync_ok = 1'b1;
            default:                         sync_ok = 1'b0;
        endcase
        return width_ok && sync_ok;
    endfunction

endpackage

// File: rtl/status_capture_reg_bit_cell.sv
// -----------------------------------------------------------------------------
// status_bit_cell
// One bit of the status register: optional input synchroniser, rising-edge
// detect, and either a transparent or a sticky (set-on-rise, clear-on-read)
// storage flop with overrun tracking.
//
// Ports:
//   clock      in   block clock
//   reset_n    in   synchronous active-low reset
//   status_in  in   raw status net for this bit
//   clr        in   clear request from the read FSM (sticky bits only)
//   stat       out  registered status bit
//   ovr        out  registered overrun flag (always 0 when transparent)
// -----------------------------------------------------------------------------
module status_bit_cell
    import status_reg_pkg::*;
#(
    parameter bit STICKY      = 1'b0,
    parameter int SYNC_STAGES = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic status_in,
    input  logic clr,
    output logic stat,
    output logic ovr
);

    logic sin_s;
    logic rise_s;
    logic stat_nxt_s;
    logic ovr_nxt_s;
    logic prev_r;
    logic stat_r;
    logic ovr_r;

    generate
        if (SYNC_STAGES == SYNC_NONE) begin : g_nosync
            assign sin_s = status_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_r;

            // Synchroniser chain: status_in enters at bit 0, leaves at the top.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    sync_r <= {SYNC_STAGES{1'b0}};
                end else begin
                    sync_r <= {sync_r[SYNC_STAGES-2:0], status_in};
                end
            end

            assign sin_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    // Next-state selection for sticky and transparent behaviour.
    always_comb begin
        rise_s = sin_s & ~prev_r;
        if (STICKY) begin
            // A rise in the same cycle as a clear wins, so the edge is kept.
            stat_nxt_s = (stat_r & ~clr) | rise_s;
            // Overrun: a new edge while the previous one is still unread.
            ovr_nxt_s  = (ovr_r & ~clr) | (rise_s & stat_r & ~clr);
        end else begin
            stat_nxt_s = sin_s;
            ovr_nxt_s  = 1'b0;
        end
    end

    // Edge-detect history plus status and overrun storage.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_r <= 1'b0;
            stat_r <= 1'b0;
            ovr_r  <= 1'b0;
        end else begin
            prev_r <= sin_s;
            stat_r <= stat_nxt_s;
            ovr_r  <= ovr_nxt_s;
        end
    end

    assign stat = stat_r;
    assign ovr  = ovr_r;

endmodule

// File: rtl/status_capture_reg.sv
// -----------------------------------------------------------------------------
// status_capture_reg
// Parametrised status register between fabric status nets and the CPU bus
// bridge. Each bit is transparent or sticky; a request/acknowledge read takes
// a snapshot of the register and its overrun flags and clears the sticky bits
// that were captured. A runtime-writable mask drives a level or pulse
// interrupt.
//
// Ports:
//   clock       in   block clock
//   reset_n     in   synchronous active-low reset
//   status_in   in   [WIDTH] raw status nets
//   mask_wr     in   load mask_wdata into the interrupt mask
//   mask_wdata  in   [WIDTH] new interrupt mask
//   rd_req      in   snapshot read request (held request = one read)
//   rd_ack      out  one-cycle acknowledge, rd_data/rd_ovr valid with it
//   rd_data     out  [WIDTH] snapshot of the status register
//   rd_ovr      out  [WIDTH] snapshot of the overrun flags
//   status_out  out  [WIDTH] live status register
//   intr        out  interrupt (level, or one-cycle pulse per rising level)
// -----------------------------------------------------------------------------
module status_capture_reg
    import status_reg_pkg::*;
#(
    parameter int                   WIDTH         = 8,
    parameter logic [MAX_WIDTH-1:0] STICKY_MASK   = 32'h0000_0000,
    parameter logic [MAX_WIDTH-1:0] INT_MASK_INIT = 32'h0000_007F,
    parameter int                   SYNC_STAGES   = 0,
    parameter int                   INTR_PULSE    = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] status_in,
    input  logic             mask_wr,
    input  logic [WIDTH-1:0] mask_wdata,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_ovr,
    output logic [WIDTH-1:0] status_out,
    output logic             intr
);

    generate
        if (!params_legal(WIDTH, SYNC_STAGES)) begin : g_bad_params
            $error("status_capture_reg: WIDTH must be 1..32 and SYNC_STAGES 0, 2 or 3");
        end
    endgenerate

    localparam logic [WIDTH-1:0] STICKY_BITS = STICKY_MASK[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MASK_RESET  = INT_MASK_INIT[WIDTH-1:0];

    logic [WIDTH-1:0] stat_s;
    logic [WIDTH-1:0] ovr_s;
    logic [WIDTH-1:0] clr_s;
    logic             capture_s;
    logic             lvl_s;

    rd_state_e        state_r;
    logic             rd_ack_r;
    logic [WIDTH-1:0] rd_data_r;
    logic [WIDTH-1:0] rd_ovr_r;
    logic [WIDTH-1:0] mask_r;
    logic             lvl_r;
    logic             intr_r;

    // Per-bit storage cells.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            status_bit_cell #(
                .STICKY      (STICKY_BITS[i]),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_cell (
                .clock     (clock),
                .reset_n   (reset_n),
                .status_in (status_in[i]),
                .clr       (clr_s[i]),
                .stat      (stat_s[i]),
                .ovr       (ovr_s[i])
            );
        end
    endgenerate

    // Capture strobe and the matching clear of the captured sticky bits.
    // The clear acts on the same edge as the snapshot, so nothing set before
    // the snapshot can be lost and a rise on that edge survives in stat.
    always_comb begin
        capture_s = (state_r == RD_IDLE) && rd_req;
        if (capture_s) begin
            clr_s = stat_s & STICKY_BITS;
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
    end

    // Read handshake FSM with registered acknowledge and snapshot.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r   <= RD_IDLE;
            rd_ack_r  <= 1'b0;
            rd_data_r <= {WIDTH{1'b0}};
            rd_ovr_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                RD_IDLE: begin
                    if (rd_req) begin
                        rd_data_r <= stat_s;
                        rd_ovr_r  <= ovr_s;
                        rd_ack_r  <= 1'b1;
                        state_r   <= RD_ACK;
                    end else begin
                        rd_ack_r  <= 1'b0;
                    end
                end
                RD_ACK: begin
                    rd_ack_r <= 1'b0;
                    // A request still high here is the same read; park in HOLD.
                    if (rd_req) begin
                        state_r <= RD_HOLD;
                    end else begin
                        state_r <= RD_IDLE;
                    end
                end
                RD_HOLD: begin
                    rd_ack_r <= 1'b0;
                    if (!rd_req) begin
                        state_r <= RD_IDLE;
                    end else begin
                        state_r <= RD_HOLD;
                    end
                end
                default: begin
                    rd_ack_r <= 1'b0;
                    state_r  <= RD_IDLE;
                end
            endcase
        end
    end

    // Interrupt level from the live register under the current mask.
    always_comb begin
        lvl_s = |(stat_s & mask_r);
    end

    // Mask register, registered level and interrupt output. In pulse mode
    // the output is the 0->1 transition of the registered level, computed
    // one stage early so intr itself stays a flop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mask_r <= MASK_RESET;
            lvl_r  <= 1'b0;
            intr_r <= 1'b0;
        end else begin
            if (mask_wr) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
            lvl_r <= lvl_s;
            if (INTR_PULSE != 0) begin
                intr_r <= lvl_s & ~lvl_r;
            end else begin
                intr_r <= lvl_s;
            end
        end
    end

    assign rd_ack     = rd_ack_r;
    assign rd_data    = rd_data_r;
    assign rd_ovr     = rd_ovr_r;
    assign status_out = stat_s;
    assign intr       = intr_r;

endmodule

// File: doc/status_capture_reg.md
Name: status_capture_reg

Overview:
- Parametrised status register for the UDB fabric; the next generation of the fixed 8-bit status register.
- Width runs 1..32 bits. Each bit is set by parameter to transparent or sticky, where sticky means latched on a rising edge and cleared on read.
- Adds a request/acknowledge snapshot read with clear-on-read, per-bit overrun detection, a runtime-writable interrupt mask, optional input synchronisers, and a level or pulse interrupt.
- Sits between fabric status nets and the CPU-side bus bridge.

Parameters:
- WIDTH, 8: number of status bits, legal range 1..32.
- STICKY_MASK, 0: bit i = 1 makes bit i sticky; 0 makes it transparent.
- INT_MASK_INIT, 8'h7F (zero-extended to WIDTH): reset value of the interrupt mask.
- SYNC_STAGES, 0: number of input synchroniser flops, legal values 0, 2 or 3.
- INTR_PULSE, 0: 0 gives a level interrupt; 1 gives a one-cycle pulse on each rising edge of the level.

Ports:
- clock  in  1  single block clock.
- reset_n  in  1  synchronous, active-low reset.
- status_in  in  WIDTH  raw status nets.
- mask_wr  in  1  loads mask_wdata into the mask register.
- mask_wdata  in  WIDTH  new interrupt mask.
- rd_req  in  1  snapshot read request.
- rd_ack  out  1  one-cycle acknowledge; rd_data is valid while rd_ack = 1.
- rd_data  out  WIDTH  snapshot of the status register.
- rd_ovr  out  WIDTH  snapshot of the overrun flags.
- status_out  out  WIDTH  live status register contents.
- intr  out  1  interrupt.

Behaviour:
- Reset (synchronous, reset_n = 0 at a clock edge):
  - stat, ovr, prev, sync chain, rd_data, rd_ack, rd_ovr, intr and the FSM state all go to 0 / IDLE.
  - mask_reg goes to INT_MASK_INIT.
  - Because prev resets to 0, an input that is already high counts as a rising edge in the first cycle after reset is released.
- Input path:
  - sin = status_in delayed by SYNC_STAGES flops.
  - rise = sin & ~prev; prev <= sin every cycle.
- Transparent bit i: stat[i] <= sin[i]. Latency is SYNC_STAGES+1 cycles from status_in to status_out.
- Sticky bit i:
  - stat[i] <= (stat[i] & ~clr[i]) | rise[i]. Set wins over a simultaneous clear, so the edge is not lost.
  - ovr[i] <= (ovr[i] & ~clr[i]) | (rise[i] & stat[i] & ~clr[i]).
  - For transparent bits, ovr[i] is always 0.
- Read FSM states: IDLE, ACK, HOLD.
  - IDLE with rd_req = 1: rd_data <= stat, rd_ovr <= ovr, clr = stat & STICKY_MASK for that same edge, rd_ack <= 1, go to ACK.
  - ACK: rd_ack <= 0. If rd_req = 1, go to HOLD; otherwise go to IDLE.
  - HOLD: stay until rd_req = 0, then go to IDLE. A held request yields exactly one read.
  - clr is 0 in every other cycle. rd_data and rd_ovr hold their values until the next read.
  - A sticky bit that rises in the capture cycle is absent from rd_data but remains set in stat.
- Interrupt:
  - lvl = |(stat & mask_reg), registered. intr therefore follows stat by 1 cycle.
  - INTR_PULSE = 1: intr = lvl & ~lvl_d, a one-cycle pulse per 0→1 transition of lvl.
  - mask_wr takes effect on the next edge; the new mask affects intr one cycle later.
  - mask_wr and a read in the same cycle are independent of each other.
- Reset during ACK or HOLD returns the FSM to IDLE with rd_ack = 0. No clear is applied at the reset edge; everything is reset anyway.
- WIDTH < 32: no unused bits exist in any port.

Decomposition:
- Package status_reg_pkg holds:
  - the read FSM state enum (IDLE, ACK, HOLD);
  - MAX_WIDTH = 32;
  - legal SYNC_STAGES values and an elaboration check function.
- One sub-module, status_bit_cell: a per-bit register with sticky/transparent select, edge detect, overrun and clear. It is instantiated WIDTH times via generate.
- The FSM and the interrupt logic live in the top level.

Test Plan:
- Reset then release, WIDTH = 8, STICKY_MASK = 8'h0F, status_in = 8'h81 held high → status_out = 8'h81 one cycle after release. Bit 0 stays set after status_in[0] drops; bit 7 follows the input.
- Sticky bit 2 rises, then 3 cycles later rd_req pulses → rd_ack high for exactly one cycle with rd_data[2] = 1; status_out[2] = 0 on the next cycle.
- Rise on sticky bit 1 in the same cycle rd_req is accepted → rd_data[1] = 0 and status_out[1] stays 1. The next read returns 1.
- Two rising edges on sticky bit 3 before any read → rd_ovr[3] = 1. A second read returns rd_ovr = 0.
- INT_MASK_INIT = 8'h7F, bit 7 set → intr stays 0. mask_wr with 8'h80 → intr = 1 two cycles after mask_wr. With INTR_PULSE = 1, intr is high for exactly one cycle.
- rd_req held high for 10 cycles → a single rd_ack. reset_n driven low while in HOLD → rd_ack = 0, FSM in IDLE, stat = 0.
